// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO between the cpu data port and the memory bus.
//   Buffers cpu stores and drains them in order over a valid/ready write channel.
//   Loads forward from the youngest matching buffered store, else bus read data.
// Ports:
//   clk, reset_n (synchronous, active-high despite the name)
//   cpu_addr_i / cpu_wr_data_i / cpu_wr_sig_i : cpu store/load request
//   cpu_rd_data_o                             : load data (combinational)
//   bus_rd_addr_o / bus_rd_data_i             : pass-through bus read
//   bus_wr_valid_o / bus_wr_ready_i / bus_wr_addr_o / bus_wr_data_o : drain channel
//   full_o / drained_o / overflow_o           : occupancy and sticky drop flag
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wr_data_i,
  input  logic              cpu_wr_sig_i,
  output logic [DATA_W-1:0] cpu_rd_data_o,
  output logic [ADDR_W-1:0] bus_rd_addr_o,
  input  logic [DATA_W-1:0] bus_rd_data_i,
  output logic              bus_wr_valid_o,
  input  logic              bus_wr_ready_i,
  output logic [ADDR_W-1:0] bus_wr_addr_o,
  output logic [DATA_W-1:0] bus_wr_data_o,
  output logic              full_o,
  output logic              drained_o,
  output logic              overflow_o
);
  localparam int PW = $clog2(DEPTH);
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0] count_q, count_d;
  logic overflow_q, overflow_d;
  logic push, pop;
  assign bus_wr_valid_o = count_q != '0;
  assign full_o = count_q == (PW+1)'(DEPTH);
  assign drained_o = count_q == '0;
  assign overflow_o = overflow_q;
  assign bus_rd_addr_o = cpu_addr_i;
  assign bus_wr_addr_o = addr_q[rd_ptr_q];
  assign bus_wr_data_o = data_q[rd_ptr_q];
  assign pop = bus_wr_valid_o & bus_wr_ready_i;
  assign push = cpu_wr_sig_i & (~full_o | pop);
  assign wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
  assign rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
  assign count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);
  assign overflow_d = overflow_q | (cpu_wr_sig_i & ~push);
  // Walk entries oldest to youngest so the last match (youngest) wins.
  always_comb begin
    cpu_rd_data_o = bus_rd_data_i;
    for (int i = 0; i < DEPTH; i++)
      if ((PW+1)'(i) < count_q && addr_q[rd_ptr_q + PW'(i)][ADDR_W-1:2] == cpu_addr_i[ADDR_W-1:2])
        cpu_rd_data_o = data_q[rd_ptr_q + PW'(i)];
  end
  always_ff @(posedge clk) begin
    if (reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      overflow_q <= overflow_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr_q] <= cpu_addr_i;
      data_q[wr_ptr_q] <= cpu_wr_data_i;
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed plus randomized checks of store_buffer against a queue model.
module tb_store_buffer;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic [31:0] cpu_addr_i = '0;
  logic [31:0] cpu_wr_data_i = '0;
  logic cpu_wr_sig_i = 1'b0;
  logic [31:0] cpu_rd_data_o;
  logic [31:0] bus_rd_addr_o;
  logic [31:0] bus_rd_data_i = '0;
  logic bus_wr_valid_o;
  logic bus_wr_ready_i = 1'b0;
  logic [31:0] bus_wr_addr_o;
  logic [31:0] bus_wr_data_o;
  logic full_o, drained_o, overflow_o;
  typedef struct packed { logic [31:0] a; logic [31:0] d; } ent_t;
  ent_t q[$];
  logic m_ovf = 1'b0;
  int npass = 0;
  int ntotal = 0;
  store_buffer dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_addr_i(cpu_addr_i), .cpu_wr_data_i(cpu_wr_data_i), .cpu_wr_sig_i(cpu_wr_sig_i),
    .cpu_rd_data_o(cpu_rd_data_o), .bus_rd_addr_o(bus_rd_addr_o), .bus_rd_data_i(bus_rd_data_i),
    .bus_wr_valid_o(bus_wr_valid_o), .bus_wr_ready_i(bus_wr_ready_i),
    .bus_wr_addr_o(bus_wr_addr_o), .bus_wr_data_o(bus_wr_data_o),
    .full_o(full_o), .drained_o(drained_o), .overflow_o(overflow_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntotal++;
    assert (got === exp) npass++;
    else $error("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask
  function automatic logic [31:0] fwd(input logic [31:0] a, input logic [31:0] busd);
    logic [31:0] r = busd;
    foreach (q[i]) if (q[i].a[31:2] == a[31:2]) r = q[i].d;
    return r;
  endfunction
  task automatic check_all();
    chk("valid", 32'(bus_wr_valid_o), 32'(q.size() != 0));
    chk("full", 32'(full_o), 32'(q.size() == 4));
    chk("drained", 32'(drained_o), 32'(q.size() == 0));
    chk("overflow", 32'(overflow_o), 32'(m_ovf));
    chk("rd_addr", bus_rd_addr_o, cpu_addr_i);
    chk("rd_data", cpu_rd_data_o, fwd(cpu_addr_i, bus_rd_data_i));
    if (q.size() != 0) begin
      chk("wr_addr", bus_wr_addr_o, q[0].a);
      chk("wr_data", bus_wr_data_o, q[0].d);
    end
  endtask
  task automatic cyc(input logic rst, input logic wr, input logic rdy, input logic [31:0] a, input logic [31:0] d);
    logic pop, push;
    @(negedge clk);
    reset_n = rst;
    cpu_wr_sig_i = wr;
    bus_wr_ready_i = rdy;
    cpu_addr_i = a;
    cpu_wr_data_i = d;
    bus_rd_data_i = $urandom;
    #1 check_all();
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_ovf = 1'b0;
    end else begin
      pop = rdy && q.size() != 0;
      push = wr && (q.size() < 4 || pop);
      if (pop) void'(q.pop_front());
      if (push) q.push_back('{a: a, d: d});
      if (wr && !push) m_ovf = 1'b1;
    end
  endtask
  initial begin
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    q.delete();
    // reset state and single store latency
    cyc(0, 1, 1, 32'h100, 32'h11);
    cyc(0, 0, 1, 32'h200, 0);
    cyc(0, 0, 1, 32'h200, 0);
    // fill, overflow drop, in-order drain with sticky overflow
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 32'(i * 4), 32'(32'hA0 + i));
    cyc(0, 1, 0, 32'h10, 32'hDEAD);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 32'(i * 4), 0);
    // forwarding from youngest match, miss passes bus data
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 32'h20, 32'hAA);
    cyc(0, 1, 0, 32'h20, 32'hBB);
    cyc(0, 0, 0, 32'h20, 0);
    cyc(0, 0, 0, 32'h22, 0);
    cyc(0, 0, 0, 32'h24, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 32'h20, 0);
    // full with simultaneous pop accepts the store
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 32'(32'h40 + i * 4), 32'(32'hC0 + i));
    cyc(0, 1, 1, 32'h44, 32'hC4);
    cyc(0, 0, 0, 32'h44, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 32'h4C, 0);
    // pointer wrap with toggling ready
    for (int i = 0; i < 10; i++) cyc(0, 1, 1'(i % 2 == 0), 32'($urandom_range(0, 5) * 4), $urandom);
    for (int i = 0; i < 8; i++) cyc(0, 0, 1'(i % 2 == 0), 32'($urandom_range(0, 5) * 4), 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 0);
    // reset with buffered stores and overflow set
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 32'(i * 4), 32'(i));
    cyc(1, 0, 0, 32'h8, 0);
    cyc(0, 0, 1, 32'h8, 0);
    cyc(0, 0, 1, 32'h8, 0);
    // randomized traffic
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 60) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0),
          32'($urandom_range(0, 7) * 4 + $urandom_range(0, 3)), $urandom);
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule
